rpu_ctrl: RTL
=============

# rpu_ctrl

Sequencing controller for the NOU receive packet unit (RPU). It accepts a decoded packet from the ibd decoder and strobes the RPU header/address register stage. It then arbitrates for buffer space with the buffer unit, retrying when the grant reports no space. Finally it issues the packet's flits one per handshake to the AXI write path and returns a completion response to the response encoder.

## Interface
Parameters:
- FLIT_W, default `NOU_FLIT_SZ_WIDTH: width of the flit count and flit index.
- BACKOFF_CYCLES, default 16: idle cycles between a failed grant and the next request. Must be ≥1. Used only with the retry feature.
- MAX_RETRY, default 4: number of failed grants that causes an error completion. Must be ≥1. Used only with the retry feature.

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- clk, input, 1: clock.
- rst, input, 1: asynchronous active-high reset.
- pkt_vld, input, 1: decoded packet available from the ibd decoder.
- pkt_rdy, output, 1: controller can accept a packet. High only in IDLE.
- lreg_vld, output, 1: load strobe to the RPU register stage. Equals pkt_vld & pkt_rdy.
- pkt_flit_num_q, input, FLIT_W: registered flit count from the RPU register stage.
- buf_req, output, 1: buffer allocation request to the buffer unit.
- gnt_buf_vld, input, 1: grant valid from the buffer unit.
- gnt_buf_status, input, 1: grant status. 0 = space allocated, 1 = no space.
- flit_vld, output, 1: flit write request to the AXI write master.
- flit_rdy, input, 1: the AXI write master accepts the flit.
- flit_idx, output, FLIT_W: index of the current flit, starting at 0.
- flit_last, output, 1: the current flit is the final one.
- resp_vld, output, 1: completion response valid.
- resp_rdy, input, 1: completion response accepted.
- resp_err, output, 1: completion is an error (retries exhausted).
- busy, output, 1: state is not IDLE.

## Operation
- States: IDLE, REQ, BACKOFF, XFER, RESP. Encoded as rpu_state_e.
- IDLE:
  - pkt_rdy=1.
  - On pkt_vld: lreg_vld=1 and move to REQ. The retry count is cleared.
- REQ:
  - buf_req=1.
  - gnt_buf_vld with status 0: move to XFER if pkt_flit_num_q≠0; otherwise move to RESP (header-only packet). flit_idx is cleared.
  - gnt_buf_vld with status 1: treated as a failure (see Configuration).
  - No grant: remain in REQ.
- XFER:
  - flit_vld=1.
  - flit_last = (flit_idx == pkt_flit_num_q−1).
  - On flit_vld & flit_rdy: flit_idx increments. If flit_last is set, move to RESP.
  - flit_idx is unsigned FLIT_W. The count is never compared beyond pkt_flit_num_q−1, so it does not wrap.
- RESP:
  - resp_vld=1 and resp_err is held.
  - On resp_rdy: move to IDLE and clear resp_err.
- gnt_buf_vld in any state other than REQ is ignored.
- pkt_vld outside IDLE is not accepted. The decoder must hold it.

## Timing
- Reset values: state=IDLE, pkt_rdy=1, busy=0, and every other output 0. Counters are 0.
- Reset mid-operation abandons the packet. No response is sent and no output stays active.
- lreg_vld is combinational in the acceptance cycle. REQ starts the next cycle, so buf_req is high 1 cycle after acceptance.
- The register stage captures buffer addresses on the grant cycle. The first flit_vld appears 1 cycle after the grant.
- flit_vld, flit_idx and flit_last stay stable until flit_rdy. There is one flit per cycle at most.
- resp_vld stays stable until resp_rdy. pkt_rdy is high the cycle after resp_rdy.
- Minimum packet period for N flits with zero-wait handshakes: 1 (IDLE) + 1 (REQ) + N + 1 (RESP) cycles.

## Configuration
- Macro: NOU_RPU_RETRY_BACKOFF_EN.
- Defined:
  - A failed grant increments the retry count, which is $clog2(MAX_RETRY+1) bits wide.
  - If the count reaches MAX_RETRY: move to RESP with resp_err=1, and skip XFER.
  - Otherwise: move to BACKOFF with buf_req=0 for exactly BACKOFF_CYCLES cycles, then return to REQ.
- Undefined:
  - The BACKOFF state and both counters are removed.
  - A failed grant keeps the state in REQ with buf_req held high.
  - resp_err is tied to 0.

## Structure
- Package nou_rpu_pkg holds rpu_state_e and the default BACKOFF/MAX_RETRY localparams.
- Sub-module rpu_flit_cnt holds the flit index counter and generates flit_last (clear, increment, compare against pkt_flit_num_q).
- The FSM and the backoff/retry counters stay inline.

## Test plan
- 3-flit packet, all ready signals high, grant status 0 on the first REQ cycle -> lreg_vld pulses once; flit_idx is 0,1,2 with flit_last on idx 2; resp_vld on cycle 6 with resp_err=0.
- pkt_flit_num_q=0 -> REQ goes directly to RESP; flit_vld is never asserted.
- flit_rdy low for 4 cycles on flit 1 -> flit_idx=1 and flit_vld=1 are held stable; the transfer resumes and completes correctly.
- Macro defined with BACKOFF_CYCLES=2 and MAX_RETRY=2, two status=1 grants -> buf_req low for 2 cycles after the first failure; the second failure gives resp_vld=1 with resp_err=1; no flits.
- Macro undefined, status=1 for 5 grants then status=0 -> buf_req stays high throughout; normal completion with resp_err=0.
- rst asserted during XFER at flit_idx=1 -> all outputs are 0 and pkt_rdy=1 immediately; a new packet then completes normally.

Source files
------------

// File: rtl/nou_rpu_pkg.sv
// -----------------------------------------------------------------------------
// nou_rpu_pkg
// Shared types and defaults for the NOU receive packet unit (RPU) controller.
//   rpu_state_e              : sequencing FSM state encoding
//   RPU_BACKOFF_CYCLES_DEF   : default idle cycles after a failed buffer grant
//   RPU_MAX_RETRY_DEF        : default failed grants before an error completion
// NOU_FLIT_SZ_WIDTH gets a fallback value here when the surrounding build does
// not provide one.
// -----------------------------------------------------------------------------
`ifndef NOU_FLIT_SZ_WIDTH
`define NOU_FLIT_SZ_WIDTH 8
`endif

package nou_rpu_pkg;

    typedef enum logic [2:0] {
        RPU_IDLE    = 3'd0,
        RPU_REQ     = 3'd1,
        RPU_BACKOFF = 3'd2,
        RPU_XFER    = 3'd3,
        RPU_RESP    = 3'd4
    } rpu_state_e;

    localparam int RPU_BACKOFF_CYCLES_DEF = 16;
    localparam int RPU_MAX_RETRY_DEF      = 4;

endpackage

// File: rtl/rpu_flit_cnt.sv
// -----------------------------------------------------------------------------
// rpu_flit_cnt
// Flit index counter for the RPU controller.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : restart the index at 0 (buffer grant accepted)
//   inc        : advance the index (flit handshake)
//   flit_num   : number of flits in the current packet
//   idx        : current flit index
//   last       : idx addresses the final flit (idx == flit_num - 1)
// -----------------------------------------------------------------------------
`ifndef NOU_FLIT_SZ_WIDTH
`define NOU_FLIT_SZ_WIDTH 8
`endif

module rpu_flit_cnt #(
    parameter int FLIT_W = `NOU_FLIT_SZ_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [FLIT_W-1:0] flit_num,
    output logic [FLIT_W-1:0] idx,
    output logic              last
);

    localparam logic [FLIT_W-1:0] ONE = FLIT_W'(1);

    logic [FLIT_W-1:0] idx_q;
    logic [FLIT_W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = idx_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;
    // For a zero-flit packet flit_num - 1 wraps to all ones; the controller
    // never enters the transfer phase in that case, so the value is unused.
    assign last = (idx_q == (flit_num - ONE));

endmodule

// File: rtl/rpu_ctrl.sv
// -----------------------------------------------------------------------------
// rpu_ctrl
// Sequencing controller for the NOU receive packet unit. Accepts a decoded
// packet, strobes the RPU register stage, arbitrates for buffer space, issues
// the packet's flits to the AXI write path and returns a completion response.
//
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   pkt_vld / pkt_rdy            : decoded packet handshake (ibd decoder)
//   lreg_vld                     : register stage load strobe (acceptance cycle)
//   pkt_flit_num_q               : registered flit count of the current packet
//   buf_req                      : buffer allocation request
//   gnt_buf_vld / gnt_buf_status : buffer grant (status 1 = no space)
//   flit_vld / flit_rdy          : flit write handshake to the AXI write master
//   flit_idx, flit_last          : current flit index / final-flit flag
//   resp_vld / resp_rdy          : completion response handshake
//   resp_err                     : completion reports exhausted retries
//   busy                         : controller is not idle
//
// Build option NOU_RPU_RETRY_BACKOFF_EN: when defined, failed grants are
// counted, followed by BACKOFF_CYCLES idle cycles, and MAX_RETRY failures end
// the packet with an error completion. When undefined, a failed grant simply
// keeps the request asserted and resp_err is constant 0.
// -----------------------------------------------------------------------------
`ifndef NOU_FLIT_SZ_WIDTH
`define NOU_FLIT_SZ_WIDTH 8
`endif

module rpu_ctrl
    import nou_rpu_pkg::*;
#(
    parameter int FLIT_W         = `NOU_FLIT_SZ_WIDTH,
    parameter int BACKOFF_CYCLES = RPU_BACKOFF_CYCLES_DEF,
    parameter int MAX_RETRY      = RPU_MAX_RETRY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_vld,
    output logic              pkt_rdy,
    output logic              lreg_vld,
    input  logic [FLIT_W-1:0] pkt_flit_num_q,
    output logic              buf_req,
    input  logic              gnt_buf_vld,
    input  logic              gnt_buf_status,
    output logic              flit_vld,
    input  logic              flit_rdy,
    output logic [FLIT_W-1:0] flit_idx,
    output logic              flit_last,
    output logic              resp_vld,
    input  logic              resp_rdy,
    output logic              resp_err,
    output logic              busy
);

    rpu_state_e state_q;
    rpu_state_e state_d;

    logic in_idle;
    logic in_req;
    logic in_xfer;
    logic in_resp;
    logic grant_ok;
    logic flit_hs;

    logic [FLIT_W-1:0] cnt_idx;
    logic              cnt_last;

    assign in_idle  = (state_q == RPU_IDLE);
    assign in_req   = (state_q == RPU_REQ);
    assign in_xfer  = (state_q == RPU_XFER);
    assign in_resp  = (state_q == RPU_RESP);
    assign grant_ok = in_req & gnt_buf_vld & ~gnt_buf_status;
    assign flit_hs  = in_xfer & flit_rdy;

    // The index restarts on every successful grant so a header-only packet
    // still leaves the counter in a known state for the next packet.
    rpu_flit_cnt #(
        .FLIT_W (FLIT_W)
    ) u_flit_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (grant_ok),
        .inc      (flit_hs),
        .flit_num (pkt_flit_num_q),
        .idx      (cnt_idx),
        .last     (cnt_last)
    );

`ifdef NOU_RPU_RETRY_BACKOFF_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int BO_W    = (BACKOFF_CYCLES < 1) ? 1 : $clog2(BACKOFF_CYCLES + 1);

    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);
    localparam logic [BO_W-1:0]    BO_LAST   = BO_W'(BACKOFF_CYCLES - 1);
    localparam logic [BO_W-1:0]    BO_ONE    = BO_W'(1);

    logic               grant_fail;
    logic [RETRY_W-1:0] retry_cnt_q;
    logic [RETRY_W-1:0] retry_cnt_d;
    logic [RETRY_W-1:0] retry_inc;
    logic [BO_W-1:0]    bo_cnt_q;
    logic [BO_W-1:0]    bo_cnt_d;
    logic               resp_err_q;
    logic               resp_err_d;

    assign grant_fail = in_req & gnt_buf_vld & gnt_buf_status;
    // retry_cnt_q stays below MAX_RETRY while in REQ, so this cannot overflow.
    assign retry_inc  = retry_cnt_q + RETRY_ONE;

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        bo_cnt_d    = bo_cnt_q;
        resp_err_d  = resp_err_q;
        unique case (state_q)
            RPU_IDLE: begin
                if (pkt_vld) begin
                    state_d     = RPU_REQ;
                    retry_cnt_d = '0;
                    resp_err_d  = 1'b0;
                end
            end
            RPU_REQ: begin
                if (grant_ok) begin
                    state_d = (pkt_flit_num_q != '0) ? RPU_XFER : RPU_RESP;
                end else if (grant_fail) begin
                    retry_cnt_d = retry_inc;
                    if (retry_inc == RETRY_MAX) begin
                        state_d    = RPU_RESP;
                        resp_err_d = 1'b1;
                    end else begin
                        state_d  = RPU_BACKOFF;
                        bo_cnt_d = '0;
                    end
                end
            end
            RPU_BACKOFF: begin
                // bo_cnt_q counts the backoff cycles already spent; the last
                // one hands control back to REQ.
                if (bo_cnt_q == BO_LAST) begin
                    state_d = RPU_REQ;
                end else begin
                    bo_cnt_d = bo_cnt_q + BO_ONE;
                end
            end
            RPU_XFER: begin
                if (flit_rdy && cnt_last) begin
                    state_d = RPU_RESP;
                end
            end
            RPU_RESP: begin
                if (resp_rdy) begin
                    state_d    = RPU_IDLE;
                    resp_err_d = 1'b0;
                end
            end
            default: begin
                state_d = RPU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RPU_IDLE;
            retry_cnt_q <= '0;
            bo_cnt_q    <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_cnt_q <= retry_cnt_d;
            bo_cnt_q    <= bo_cnt_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign resp_err = resp_err_q;
`else
    // A failed grant leaves the FSM in REQ, so buf_req simply stays high.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RPU_IDLE: begin
                if (pkt_vld) begin
                    state_d = RPU_REQ;
                end
            end
            RPU_REQ: begin
                if (grant_ok) begin
                    state_d = (pkt_flit_num_q != '0) ? RPU_XFER : RPU_RESP;
                end
            end
            RPU_XFER: begin
                if (flit_rdy && cnt_last) begin
                    state_d = RPU_RESP;
                end
            end
            RPU_RESP: begin
                if (resp_rdy) begin
                    state_d = RPU_IDLE;
                end
            end
            default: begin
                state_d = RPU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RPU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign resp_err = 1'b0;
`endif

    assign pkt_rdy  = in_idle;
    assign lreg_vld = pkt_vld & in_idle;
    assign buf_req  = in_req;
    assign flit_vld = in_xfer;
    // Index and last flag are only meaningful alongside flit_vld; outside the
    // transfer phase they read as 0 so no stale value lingers on the bus.
    assign flit_idx  = in_xfer ? cnt_idx : '0;
    assign flit_last = in_xfer & cnt_last;
    assign resp_vld  = in_resp;
    assign busy      = ~in_idle;

endmodule
